// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART player transmit path.
// The feeder FSM state encoding lives here so the feeder and any debug
// or checker logic agree on one encoding.
package uart_pkg;

    // Feeder handshake states, in launch order.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_e;

    // The transmitter sees uart_en through a two-flop edge detector, so a
    // shorter pulse could be missed entirely.
    localparam int EN_HOLD_MIN = 2;

    // Cycles the feeder waits in WAIT_BUSY before abandoning a byte
    // (only used when the watchdog is built in).
    localparam int FEEDER_TIMEOUT_CYC = 16;

    // Watchdog counter width; wide enough to hold FEEDER_TIMEOUT_CYC.
    localparam int WD_W = 5;

endpackage

// File: rtl/sync_fifo_8b.sv
// sync_fifo_8b: single-clock circular byte FIFO.
// Writes while full are dropped and reported with a one-cycle overflow
// pulse. full/empty are decoded from the registered count, so a pop in the
// same cycle does not make room for a write that sees full.
module sync_fifo_8b #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    input  logic              rd_en_i,
    output logic [7:0]        rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o
);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              overflow_q;
    logic              push;
    logic              pop;

    assign full_o     = (count_q == (ADDR_W + 1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign level_o    = count_q;
    assign overflow_o = overflow_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    assign push = wr_en_i && !full_o;
    assign pop  = rd_en_i && !empty_o;

    // Occupancy next state: push and pop together leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end
    end

    // Pointers, count and overflow flag; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            count_q    <= count_d;
            overflow_q <= wr_en_i && full_o;
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: queues bytes and hands them one at a time to the UART
// transmitter through its edge-triggered uart_en/uart_din interface.
// Handshake: a byte is launched only from IDLE while the FIFO is non-empty
// and uart_tx_busy is low; uart_din is loaded on that launch and held until
// the next one, uart_en is high for EN_HOLD cycles, then the feeder waits
// for busy to rise and fall before it may launch again.
// Optional build macro UART_FEEDER_TIMEOUT_EN adds a WAIT_BUSY watchdog that
// abandons the byte and sets the sticky tx_err flag; without it tx_err is 0.
// state_dbg exposes the FSM state for debug and checkers.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int EN_HOLD = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              uart_tx_busy,
    output logic              uart_en,
    output logic [7:0]        uart_din,
    output logic              tx_err,
    output logic [1:0]        state_dbg
);

    // A too-short enable would slip past the transmitter's edge detector.
    localparam int EN_HOLD_EFF = (EN_HOLD < EN_HOLD_MIN) ? EN_HOLD_MIN : EN_HOLD;
    localparam int HOLD_W      = $clog2(EN_HOLD_EFF + 1);

    feeder_state_e     state_q;
    logic              uart_en_q;
    logic [7:0]        uart_din_q;
    logic [HOLD_W-1:0] hold_q;
    logic [7:0]        fifo_head;
    logic              fifo_empty;
    logic              launch;

`ifdef UART_FEEDER_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(FEEDER_TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_q;
    logic            tx_err_q;
`endif

    sync_fifo_8b #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_en_i    (launch),
        .rd_data_o  (fifo_head),
        .full_o     (full),
        .empty_o    (fifo_empty),
        .level_o    (level),
        .overflow_o (overflow)
    );

    // A launch pops the head and starts the enable pulse in the same edge.
    // Checking busy here also keeps a post-reset feeder off a frame the
    // transmitter is still finishing.
    assign launch = (state_q == IDLE) && !fifo_empty && !uart_tx_busy;

    assign empty     = fifo_empty;
    assign uart_en   = uart_en_q;
    assign uart_din  = uart_din_q;
    assign state_dbg = state_q;

`ifdef UART_FEEDER_TIMEOUT_EN
    assign tx_err = tx_err_q;
`else
    assign tx_err = 1'b0;
`endif

    // Handshake FSM with registered uart_en/uart_din and optional watchdog.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            uart_en_q  <= 1'b0;
            uart_din_q <= 8'h00;
            hold_q     <= '0;
`ifdef UART_FEEDER_TIMEOUT_EN
            wd_q       <= '0;
            tx_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        uart_din_q <= fifo_head;
                        uart_en_q  <= 1'b1;
                        hold_q     <= HOLD_W'(1);
                        state_q    <= PULSE;
                    end
                end
                PULSE: begin
                    // hold_q counts enable-high cycles already elapsed.
                    if (hold_q == HOLD_W'(EN_HOLD_EFF)) begin
                        uart_en_q <= 1'b0;
                        state_q   <= WAIT_BUSY;
`ifdef UART_FEEDER_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
`ifdef UART_FEEDER_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        // Transmitter never accepted the byte: drop it.
                        tx_err_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: bench for uart_tx_feeder with a behavioural UART
// transmitter (two-flop enable edge detector, 10-bit frames) whose decoded
// frames are checked against an expected-byte queue.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int EN_HOLD   = 2;
    localparam int BIT_CYC   = 2;
    localparam int DRAIN_MAX = 4000;
    localparam int WAIT_MAX  = 200;

    // ---------------- clock / reset / DUT ----------------
    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              uart_tx_busy;
    logic              uart_en;
    logic [7:0]        uart_din;
    logic              tx_err;
    logic [1:0]        state_dbg;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    uart_tx_feeder #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .EN_HOLD (EN_HOLD)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .uart_tx_busy (uart_tx_busy),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .tx_err       (tx_err),
        .state_dbg    (state_dbg)
    );

    // ---------------- transmitter model ----------------
    logic       model_en = 1'b1;
    logic       force_busy = 1'b0;
    logic       model_busy = 1'b0;
    logic       frame_valid = 1'b0;
    logic [1:0] en_sync = 2'b00;
    logic [9:0] frame_sh = 10'h3ff;
    logic [9:0] rx_sh = 10'h000;
    int         bit_idx = 0;
    int         cyc_in_bit = 0;

    assign uart_tx_busy = model_busy | force_busy;

    always @(posedge sys_clk) begin
        en_sync     <= {en_sync[0], uart_en};
        frame_valid <= 1'b0;
        if (!model_busy) begin
            if (model_en && en_sync[0] && !en_sync[1]) begin
                model_busy <= 1'b1;
                frame_sh   <= {1'b1, uart_din, 1'b0};
                bit_idx    <= 0;
                cyc_in_bit <= 0;
            end
        end else if (cyc_in_bit == BIT_CYC - 1) begin
            cyc_in_bit <= 0;
            rx_sh      <= {frame_sh[0], rx_sh[9:1]};
            frame_sh   <= {1'b1, frame_sh[9:1]};
            if (bit_idx == 9) begin
                model_busy  <= 1'b0;
                frame_valid <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 1;
            end
        end else begin
            cyc_in_bit <= cyc_in_bit + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_byte;
    logic [9:0] exp_frame;

    always @(negedge sys_clk) begin
        if (frame_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL frame_unexpected: got frame %b, required no frame", rx_sh);
            end else begin
                exp_byte  = exp_q.pop_front();
                exp_frame = {1'b1, exp_byte, 1'b0};
                if (rx_sh !== exp_frame) begin
                    tests_failed++;
                    $display("FAIL frame_data: got frame %b, required %b", rx_sh, exp_frame);
                end
            end
        end
    end

    // ---------------- enable protocol monitor ----------------
    logic       busy_at_edge = 1'b0;
    logic       en_prev = 1'b0;
    int         en_run = 0;
    logic [7:0] din_at_rise = 8'h00;

    always @(posedge sys_clk) busy_at_edge <= uart_tx_busy;

    always @(negedge sys_clk) begin
        if (uart_en && !en_prev) begin
            tests_run++;
            if (busy_at_edge !== 1'b0) begin
                tests_failed++;
                $display("FAIL en_launch_busy: got busy %b at launch edge, required 0", busy_at_edge);
            end
            en_run = 1;
            din_at_rise = uart_din;
        end else if (uart_en) begin
            en_run++;
        end else if (en_prev) begin
            tests_run++;
            if (en_run != EN_HOLD || uart_din !== din_at_rise) begin
                tests_failed++;
                $display("FAIL en_pulse: got width %0d din %h, required width %0d din %h",
                         en_run, uart_din, EN_HOLD, din_at_rise);
            end
        end
        en_prev = uart_en;
    end

    // ---------------- driver tasks / tests ----------------
    task automatic wait_drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && uart_tx_busy === 1'b0 && state_dbg === IDLE && empty === 1'b1)
               && n < DRAIN_MAX) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= DRAIN_MAX) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_drain: got %0d bytes pending after %0d cycles, required 0", name, exp_q.size(), n);
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if ({level, empty, full} !== {5'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_fifo: got level %0d empty %b full %b, required 0 1 0", level, empty, full);
        end
        tests_run++;
        if ({overflow, uart_en, uart_din, tx_err} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ovf %b en %b din %h err %b, required 0 0 00 0",
                     overflow, uart_en, uart_din, tx_err);
        end
        tests_run++;
        if (state_dbg !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d, required %0d", state_dbg, IDLE);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_single();
        @(negedge sys_clk);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge sys_clk);                      // after edge 1
        wr_en = 1'b0;
        tests_run++;
        if ({level, empty, uart_en} !== {5'd1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_edge1: got level %0d empty %b en %b, required 1 0 0", level, empty, uart_en);
        end
        @(negedge sys_clk);                      // after edge 2
        tests_run++;
        if ({uart_en, uart_din, level} !== {1'b1, 8'hA5, 5'd0}) begin
            tests_failed++;
            $display("FAIL single_edge2: got en %b din %h level %0d, required 1 a5 0", uart_en, uart_din, level);
        end
        @(negedge sys_clk);                      // after edge 3
        tests_run++;
        if (uart_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_edge3: got en %b, required 1", uart_en);
        end
        @(negedge sys_clk);                      // after edge 4
        tests_run++;
        if ({uart_en, state_dbg} !== {1'b0, WAIT_BUSY}) begin
            tests_failed++;
            $display("FAIL single_edge4: got en %b state %0d, required 0 %0d", uart_en, state_dbg, WAIT_BUSY);
        end
        @(negedge sys_clk);                      // busy seen at edge 5
        tests_run++;
        if (state_dbg !== WAIT_DONE) begin
            tests_failed++;
            $display("FAIL single_wait_done: got state %0d, required %0d", state_dbg, WAIT_DONE);
        end
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        int n;
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            if (i > 0) begin
                tests_run++;
                if (level !== 5'(i)) begin
                    tests_failed++;
                    $display("FAIL b2b_fill: got level %0d, required %0d", level, i);
                end
            end
            wr_en = (i < 3);
            wr_data = 8'(i + 1);
            if (i < 3) exp_q.push_back(8'(i + 1));
        end
        force_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (uart_en !== 1'b1 && n < WAIT_MAX) begin
                @(negedge sys_clk);
                n++;
            end
            tests_run++;
            if (n >= WAIT_MAX || level !== 5'(2 - k)) begin
                tests_failed++;
                $display("FAIL b2b_pop%0d: got level %0d after %0d cycles, required %0d", k, level, n, 2 - k);
            end
            if (k < 2) begin
                n = 0;
                while (uart_tx_busy !== 1'b1 && n < WAIT_MAX) begin
                    @(negedge sys_clk);
                    n++;
                end
                while (uart_tx_busy !== 1'b0 && n < WAIT_MAX) begin
                    @(negedge sys_clk);
                    n++;
                end
                n = 0;
                while (uart_en !== 1'b1 && n < WAIT_MAX) begin
                    @(negedge sys_clk);
                    n++;
                end
                tests_run++;
                if (n != 2) begin
                    tests_failed++;
                    $display("FAIL b2b_gap%0d: got %0d edges from busy fall to en, required 2", k, n);
                end
            end
        end
        wait_drain("b2b");
    endtask

    task automatic test_overflow();
        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge sys_clk);
            if (i == 16) begin
                tests_run++;
                if ({full, level, overflow} !== {1'b1, 5'd16, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL ovf_full: got full %b level %0d ovf %b, required 1 16 0", full, level, overflow);
                end
            end
            wr_en = 1'b1;
            wr_data = 8'($urandom_range(0, 255));
            if (i < 16) exp_q.push_back(wr_data);
        end
        @(negedge sys_clk);
        wr_en = 1'b0;
        tests_run++;
        if ({overflow, level, full} !== {1'b1, 5'd16, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovf_pulse: got ovf %b level %0d full %b, required 1 16 1", overflow, level, full);
        end
        @(negedge sys_clk);
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_once: got ovf %b, required 0", overflow);
        end
        // Write while full in the same cycle the feeder pops: still dropped.
        force_busy = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hEE;
        @(negedge sys_clk);
        wr_en = 1'b0;
        tests_run++;
        if ({overflow, level, uart_en} !== {1'b1, 5'd15, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovf_with_pop: got ovf %b level %0d en %b, required 1 15 1", overflow, level, uart_en);
        end
        wait_drain("ovf");
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        int en_seen = 0;
        @(negedge sys_clk);
        wr_en = 1'b1;
        wr_data = 8'hC3;
        exp_q.push_back(8'hC3);
        @(negedge sys_clk);
        wr_en = 1'b0;
        while (uart_tx_busy !== 1'b1 && n < WAIT_MAX) begin
            @(negedge sys_clk);
            n++;
        end
        @(negedge sys_clk);
        tests_run++;
        if (state_dbg !== WAIT_DONE) begin
            tests_failed++;
            $display("FAIL rst_pre_state: got %0d, required %0d", state_dbg, WAIT_DONE);
        end
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = (i < 4);
            wr_data = 8'($urandom_range(0, 255));
            @(negedge sys_clk);
        end
        tests_run++;
        if (level !== 5'd4) begin
            tests_failed++;
            $display("FAIL rst_queued: got level %0d, required 4", level);
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        tests_run++;
        if ({level, empty, full, overflow, uart_en, uart_din, tx_err, state_dbg}
            !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, IDLE}) begin
            tests_failed++;
            $display("FAIL rst_mid_values: got level %0d empty %b full %b ovf %b en %b din %h err %b state %0d, required 0 1 0 0 0 00 0 0",
                     level, empty, full, overflow, uart_en, uart_din, tx_err, state_dbg);
        end
        wr_en = 1'b1;
        wr_data = 8'h55;
        exp_q.push_back(8'h55);
        @(negedge sys_clk);
        wr_en = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (uart_en === 1'b1) en_seen++;
            @(negedge sys_clk);
        end
        tests_run++;
        if (en_seen != 0 || level !== 5'd1) begin
            tests_failed++;
            $display("FAIL rst_hold_off: got %0d enable cycles level %0d while busy, required 0 and 1", en_seen, level);
        end
        force_busy = 1'b0;
        wait_drain("rst_mid");
    endtask

`ifdef UART_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        model_en = 1'b0;
        @(negedge sys_clk);
        wr_en = 1'b1;
        wr_data = 8'h33;
        @(negedge sys_clk);                      // after edge 1
        wr_en = 1'b0;
        repeat (18) @(negedge sys_clk);          // after edge 19
        tests_run++;
        if ({tx_err, state_dbg} !== {1'b0, WAIT_BUSY}) begin
            tests_failed++;
            $display("FAIL timeout_early: got err %b state %0d, required 0 %0d", tx_err, state_dbg, WAIT_BUSY);
        end
        @(negedge sys_clk);                      // after edge 20
        tests_run++;
        if ({tx_err, state_dbg, level} !== {1'b1, IDLE, 5'd0}) begin
            tests_failed++;
            $display("FAIL timeout_fire: got err %b state %0d level %0d, required 1 %0d 0", tx_err, state_dbg, level, IDLE);
        end
        repeat (5) @(negedge sys_clk);
        tests_run++;
        if (tx_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got err %b, required 1", tx_err);
        end
        model_en = 1'b1;
        test_reset();
    endtask
`else
    task automatic test_timeout();
        model_en = 1'b0;
        @(negedge sys_clk);
        wr_en = 1'b1;
        wr_data = 8'h33;
        @(negedge sys_clk);
        wr_en = 1'b0;
        repeat (40) @(negedge sys_clk);
        tests_run++;
        if ({tx_err, state_dbg} !== {1'b0, WAIT_BUSY}) begin
            tests_failed++;
            $display("FAIL no_timeout: got err %b state %0d, required 0 %0d", tx_err, state_dbg, WAIT_BUSY);
        end
        model_en = 1'b1;
        test_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_timeout();
        test_single();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL final_queue: got %0d bytes pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-queue and handshake stage that sits directly upstream of the UART transmitter in the music UART player. Producers push bytes into an internal FIFO with no flow-control stalls. The feeder drains the FIFO one byte at a time into the transmitter's edge-triggered `uart_en` / `uart_din` interface and paces itself on `uart_tx_busy`, so the transmitter never receives an enable while it is mid-frame.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; must be a power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `EN_HOLD`, 2: cycles `uart_en` is held high per byte; minimum 2, because the transmitter detects the edge through a two-flop delay.
- `sys_clk`, in, 1: system clock; single clock domain.
- `sys_rst`, in, 1: reset, synchronous, active-high.
- `wr_en`, in, 1: push `wr_data` this cycle.
- `wr_data`, in, 8: byte to queue.
- `full`, out, 1: FIFO holds `DEPTH` bytes.
- `empty`, out, 1: FIFO holds 0 bytes.
- `level`, out, `ADDR_W`+1: current FIFO occupancy.
- `overflow`, out, 1: one-cycle pulse when a write is dropped.
- `uart_tx_busy`, in, 1: transmitter frame-in-progress flag.
- `uart_en`, out, 1: transmit enable to the transmitter.
- `uart_din`, out, 8: byte to the transmitter; stable for the whole handshake.
- `tx_err`, out, 1: sticky timeout flag. Present only with `UART_FEEDER_TIMEOUT_EN`; tied to 0 otherwise.

## Operation
- The FIFO is circular, with `ADDR_W`-bit read/write pointers that wrap modulo `DEPTH`. The count register is `ADDR_W`+1 bits wide.
- A write while `full` is dropped and pulses `overflow`. This holds even if a pop occurs in the same cycle, because `full` is registered.
- A simultaneous push and pop when not full leaves `level` unchanged.
- FSM states: `IDLE`, `PULSE`, `WAIT_BUSY`, `WAIT_DONE`.
- `IDLE`: if `!empty && !uart_tx_busy`, then on the next edge:
  - `uart_din` ← FIFO head,
  - pop the FIFO,
  - `uart_en` ← 1,
  - go to `PULSE`.
- `PULSE`: hold `uart_en` = 1 for `EN_HOLD` cycles total. Then `uart_en` ← 0 and go to `WAIT_BUSY`.
- `WAIT_BUSY`: on `uart_tx_busy` = 1, go to `WAIT_DONE`.
- `WAIT_DONE`: on `uart_tx_busy` = 0, go to `IDLE`.
- `uart_din` changes only on the `IDLE` → `PULSE` transition.
- `uart_en` is guaranteed low for at least 1 cycle between pulses.
- Reset, including mid-frame: on the next edge all of the following take effect:
  - FIFO cleared,
  - `level` = 0, `empty` = 1, `full` = 0,
  - `overflow` = 0, `uart_en` = 0, `uart_din` = 8'h00, `tx_err` = 0,
  - state = `IDLE`.
- After reset, no new launch occurs until `uart_tx_busy` is low, which protects a frame the transmitter was still finishing.

## Timing
- `wr_en` in cycle 0 with the FIFO empty and the transmitter idle:
  - `empty` = 0 and `level` = 1 after edge 1,
  - `uart_en` = 1 and `uart_din` valid after edge 2,
  - `uart_en` falls after edge 2+`EN_HOLD`.
- The transmitter raises busy 2 cycles after `uart_en` rises. The FSM reaches `WAIT_DONE` by the edge after busy is seen high.
- Back-to-back bytes: the next `uart_en` rises 2 edges after `uart_tx_busy` falls (`WAIT_DONE` → `IDLE` → `PULSE`).
- `overflow` asserts in the cycle after the dropped write.

## Configuration
- Macro: `UART_FEEDER_TIMEOUT_EN`.
- Defined: a 5-bit watchdog runs in `WAIT_BUSY`. If busy has not risen within 16 cycles of entering that state:
  - the byte is abandoned,
  - `tx_err` ← 1 (sticky until reset),
  - the FSM returns to `IDLE`.
- Undefined: `WAIT_BUSY` waits indefinitely, and `tx_err` is a constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum,
  - `EN_HOLD_MIN` = 2,
  - `FEEDER_TIMEOUT_CYC` = 16.
- Sub-module `sync_fifo_8b` holds the FIFO storage, pointers, count, `full` and `empty`.
- The top level holds the FSM, the `uart_din`/`uart_en` registers and the watchdog.

## Test plan
- Idle, push 8'hA5 → `uart_en` high exactly 2 cycles starting 2 cycles after `wr_en`. `uart_din` = 8'hA5 throughout. The model transmitter sends 0 10100101 1 (start, 8'hA5 LSB-first, stop).
- Push 8'h01, 8'h02, 8'h03 on consecutive cycles → three frames in order. Each `uart_en` rise occurs only after the previous busy has fallen. `level` goes 1, 2, 3, then decrements on each pop.
- Push 17 bytes with the transmitter held busy (`DEPTH` = 16) → `full` = 1 after 16 writes. The 17th write is dropped, `overflow` pulses once, and `level` = 16.
- Hold busy high, then assert `sys_rst` for 1 cycle with 4 bytes queued → all outputs take their reset values. Release, push 8'h55 → no `uart_en` until busy drops, then 8'h55 is sent.
- With `UART_FEEDER_TIMEOUT_EN` and `uart_tx_busy` tied to 0, push 8'h33 → `tx_err` = 1 after 16 cycles in `WAIT_BUSY`, FSM back in `IDLE`, `level` = 0.
